// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter type and sync-receiver FSM states.
// Used by both the VGA timing generator and the sync receiver.
package vga_timing_pkg;

    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;

    localparam int H_TOT = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
    localparam int V_TOT = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_e;

    // Increment that sticks at all-ones so a lost sync cannot wrap back into range.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_in.sv
// Two-flop synchronizer for an idle-high async sync pin, plus falling-edge flag.
// Latency: fall is high for one cycle, consumed at the 3rd edge after the pin drops; no backpressure.
module vga_sync_in (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers pixel position from external hsync/vsync, measures line/frame length and locks.
// Latency: 3 cycles pin-to-counter, 1 more to de/xpos/ypos; free-running stream, no backpressure.
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int H_FP        = DEF_H_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int V_FP        = DEF_V_FP,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       de,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [9:0] h_meas,
    output logic [9:0] v_meas
);

    localparam cnt_t LINE_TOT  = cnt_t'(H_SYNC + H_BP + H_ACT + H_FP);
    localparam cnt_t FRAME_TOT = cnt_t'(V_SYNC + V_BP + V_ACT + V_FP);
    localparam cnt_t X_FIRST   = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t X_LAST    = cnt_t'(H_SYNC + H_BP + H_ACT - 1);
    localparam cnt_t Y_FIRST   = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t Y_LAST    = cnt_t'(V_SYNC + V_BP + V_ACT - 1);
    localparam logic [7:0] LOCK_TGT = 8'(LOCK_FRAMES);

    logic h_fall, v_fall;

    vga_sync_in u_hsync (.clk(clk), .rst_n(rst_n), .pin(hsync_in), .fall(h_fall));
    vga_sync_in u_vsync (.clk(clk), .rst_n(rst_n), .pin(vsync_in), .fall(v_fall));

    cnt_t        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    cnt_t        h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic        seen_h_q, seen_h_d, seen_v_q, seen_v_d;
    sync_state_e state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        line_bad_q, line_bad_d;
    logic        locked_q, locked_d;
    logic        terr_q, terr_d;
    logic        fs_q, fs_d;
    logic        de_q, de_d;
    cnt_t        xpos_q, xpos_d, ypos_q, ypos_d;

    logic h_err, v_err, h_sat, v_sat, line_err;

    // First edge after reset only arms measurement; the partial period before it is discarded.
    always_comb begin
        h_err    = h_fall && seen_h_q && (sat_inc(hcnt_q) != LINE_TOT);
        v_err    = v_fall && seen_v_q && (sat_inc(vcnt_q) != FRAME_TOT);
        h_sat    = !h_fall && (hcnt_q == CNT_MAX - cnt_t'(1));
        v_sat    = !v_fall && h_fall && (vcnt_q == CNT_MAX - cnt_t'(1));
        line_err = h_err || h_sat || v_sat;
    end

    always_comb begin
        hcnt_d   = h_fall ? '0 : sat_inc(hcnt_q);
        h_meas_d = (h_fall && seen_h_q) ? sat_inc(hcnt_q) : h_meas_q;
        seen_h_d = seen_h_q || h_fall;
        vcnt_d   = vcnt_q;
        if (v_fall) begin
            vcnt_d = '0;
        end else if (h_fall) begin
            vcnt_d = sat_inc(vcnt_q);
        end
        v_meas_d = (v_fall && seen_v_q) ? sat_inc(vcnt_q) : v_meas_q;
        seen_v_d = seen_v_q || v_fall;
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        line_bad_d = line_bad_q;
        unique case (state_q)
            SEARCH: begin
                if (v_fall) begin
                    state_d    = MEASURE;
                    good_d     = '0;
                    line_bad_d = 1'b0;
                end
            end
            MEASURE: begin
                if (line_err) begin
                    line_bad_d = 1'b1;
                end
                if (v_fall) begin
                    line_bad_d = 1'b0;
                    if (line_bad_q || line_err || v_err) begin
                        good_d = '0;
                    end else if (good_q + 8'd1 >= LOCK_TGT) begin
                        good_d  = '0;
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (line_err || v_err) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCKED);
        terr_d   = (line_err || v_err) && (state_q != SEARCH);
        fs_d     = v_fall;
    end

    always_comb begin
        de_d = (state_q == LOCKED)
            && (hcnt_q >= X_FIRST) && (hcnt_q <= X_LAST)
            && (vcnt_q >= Y_FIRST) && (vcnt_q <= Y_LAST);
        xpos_d = de_d ? hcnt_q - X_FIRST : '0;
        ypos_d = de_d ? vcnt_q - Y_FIRST : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            h_meas_q   <= '0;
            v_meas_q   <= '0;
            seen_h_q   <= 1'b0;
            seen_v_q   <= 1'b0;
            state_q    <= SEARCH;
            good_q     <= '0;
            line_bad_q <= 1'b0;
            locked_q   <= 1'b0;
            terr_q     <= 1'b0;
            fs_q       <= 1'b0;
            de_q       <= 1'b0;
            xpos_q     <= '0;
            ypos_q     <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            h_meas_q   <= h_meas_d;
            v_meas_q   <= v_meas_d;
            seen_h_q   <= seen_h_d;
            seen_v_q   <= seen_v_d;
            state_q    <= state_d;
            good_q     <= good_d;
            line_bad_q <= line_bad_d;
            locked_q   <= locked_d;
            terr_q     <= terr_d;
            fs_q       <= fs_d;
            de_q       <= de_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign timing_err  = terr_q;
    assign h_meas      = h_meas_q;
    assign v_meas      = v_meas_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a shrunken 20x12 raster so several frames fit the cycle budget.
module tb_vga_sync_rx;
    import vga_timing_pkg::*;

    localparam int HS = 4, HB = 3, HA = 10, HF = 3, HT = HS + HB + HA + HF;
    localparam int VS = 2, VB = 2, VA = 6,  VF = 2, VT = VS + VB + VA + VF;
    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       rst_n, hsync_in, vsync_in;
    logic [9:0] xpos, ypos, h_meas, v_meas;
    logic       de, frame_start, locked, timing_err;

    always #20 clk = ~clk;

    vga_sync_rx #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .xpos(xpos), .ypos(ypos), .de(de), .frame_start(frame_start),
        .locked(locked), .timing_err(timing_err), .h_meas(h_meas), .v_meas(v_meas)
    );

    int total = 0, bad = 0, err_cnt = 0;
    int hp = 0, vl = 0, cur_h = -1, cur_v = -1, short_v = -1;
    bit short_en = 1'b0, hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Generator: drives pin levels for raster position (hp,vl) just after each falling clock edge.
    task automatic step();
        int len;
        @(negedge clk);
        hsync_in = hold ? 1'b1 : (hp >= HS);
        vsync_in = hold ? 1'b1 : (vl >= VS);
        cur_h = hp;
        cur_v = vl;
        if (timing_err === 1'b1) err_cnt++;
        len = (short_en && vl == short_v) ? HT - 1 : HT;
        hp++;
        if (hp >= len) begin
            hp = 0;
            if (short_en && vl == short_v) short_en = 1'b0;
            vl = (vl == VT - 1) ? 0 : vl + 1;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(cur_h == h && cur_v == v) && n < 2000);
        chk("run_to_within_budget", (n < 2000), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_xpos"}, xpos, 0);
        chk({tag, "_ypos"}, ypos, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_terr"}, timing_err, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_hmeas"}, h_meas, 0);
        chk({tag, "_vmeas"}, v_meas, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Frame 0: first edges arm measurement only.
        step();
        steps(2);
        chk("f0_fs_early", frame_start, 0);
        step();
        chk("f0_fs_pulse", frame_start, 1);
        chk("f0_hmeas_unlatched", h_meas, 0);
        chk("f0_vmeas_unlatched", v_meas, 0);
        step();
        chk("f0_fs_one_cycle", frame_start, 0);

        run_to(0, 0);
        steps(3);
        chk("f1_hmeas", h_meas, HT);
        chk("f1_vmeas", v_meas, VT);
        chk("f1_state", dut.state_q, MEASURE);
        chk("f1_locked", locked, 0);

        // Third vsync edge: lock appears exactly one cycle after it takes effect.
        run_to(0, 0);
        steps(2);
        chk("f2_locked_early", locked, 0);
        step();
        chk("f2_locked", locked, 1);
        chk("f2_fs", frame_start, 1);
        chk("f2_hmeas", h_meas, HT);
        chk("f2_vmeas", v_meas, VT);
        chk("f2_aligned_hcnt", dut.hcnt_q, 0);
        chk("f2_aligned_vcnt", dut.vcnt_q, 0);
        chk("f2_no_err", err_cnt, 0);

        run_to(HS + HB, VS + VB);
        steps(3);
        chk("first_px_de_early", de, 0);
        step();
        chk("first_px_de", de, 1);
        chk("first_px_x", xpos, 0);
        chk("first_px_y", ypos, 0);

        run_to(HS + HB + HA - 1, VS + VB + VA - 1);
        steps(4);
        chk("last_px_de", de, 1);
        chk("last_px_x", xpos, HA - 1);
        chk("last_px_y", ypos, VA - 1);
        step();
        chk("after_last_de", de, 0);
        chk("after_last_x", xpos, 0);
        chk("after_last_y", ypos, 0);

        // Last line of the frame one clock short; its edge coincides with vsync.
        short_en = 1'b1;
        short_v = VT - 1;
        err_cnt = 0;
        run_to(0, 0);
        steps(3);
        chk("short_hmeas", h_meas, HT - 1);
        chk("short_terr", timing_err, 1);
        chk("short_locked", locked, 0);
        chk("short_state", dut.state_q, SEARCH);
        chk("short_vcnt", dut.vcnt_q, 0);
        run_to(0, 1);
        steps(3);
        chk("short_recover_hmeas", h_meas, HT);
        chk("short_err_once", err_cnt, 1);

        run_to(0, 0);
        steps(3);
        chk("relock_measure", dut.state_q, MEASURE);
        run_to(0, 0);
        steps(3);
        chk("relock_not_yet", locked, 0);
        run_to(0, 0);
        steps(3);
        chk("relock", locked, 1);
        chk("relock_err_once", err_cnt, 1);

        // Both syncs stuck high long enough for hcnt to saturate.
        steps(5);
        err_cnt = 0;
        hold = 1'b1;
        steps(1100);
        chk("stuck_err", err_cnt, 1);
        chk("stuck_locked", locked, 0);
        chk("stuck_hcnt_sat", dut.hcnt_q, 1023);
        chk("stuck_state", dut.state_q, SEARCH);
        hold = 1'b0;

        err_cnt = 0;
        run_to(0, 0);
        run_to(0, 0);
        run_to(0, 0);
        steps(3);
        chk("stuck_relock", locked, 1);
        chk("stuck_relock_no_err", err_cnt, 0);

        // Asynchronous reset mid-line while inside the active area.
        run_to(HS + HB + 5, VS + VB + 1);
        steps(4);
        chk("pre_rst_de", de, 1);
        chk("pre_rst_x", xpos, 5);
        chk("pre_rst_y", ypos, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        err_cnt = 0;
        steps(5);
        rst_n = 1'b1;
        run_to(0, 0);
        run_to(0, 0);
        steps(3);
        chk("post_rst_no_err", err_cnt, 0);
        chk("post_rst_hmeas", h_meas, HT);
        chk("post_rst_vmeas", v_meas, VT);
        chk("post_rst_state", dut.state_q, MEASURE);
        chk("post_rst_locked", locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
